// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA unit applying up to MAX_STEP positions per cycle
// behind valid/ready request and result handshakes.
module shift_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [4:0] STEP    = 5'(MAX_STEP);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out_data;
  logic [4:0]       r_rem;
  logic [1:0]       r_op;
  logic             r_sign;
  logic [4:0]       w_step;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_shifted;
  // r_sign is only ever set for SRA, so the right-shift path serves SRL and SRA alike
  always_comb begin
    w_step    = (r_rem > STEP) ? STEP : r_rem;
    w_mask    = ~({WIDTH{1'b1}} >> w_step);
    w_shifted = (r_op == 2'b00) ? (r_data << w_step) : ((r_data >> w_step) | (r_sign ? w_mask : '0));
  end
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_out_data <= '0;
      r_rem      <= '0;
      r_op       <= '0;
      r_sign     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_data <= in_data;
          r_op   <= in_op;
          r_rem  <= in_shamt;
          r_sign <= (in_op == 2'b10) & in_data[WIDTH-1];
          if (in_shamt == 5'd0 || in_op == 2'b11) begin
            r_out_data <= in_data;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= r_rem - w_step;
          if (r_rem <= STEP) begin
            r_out_data <= w_shifted;
            r_state    <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed scoreboard bench; a monitor checks latency and result of each request.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit seen = 1'b0;
  typedef struct {
    logic [31:0] d;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  shift_sequencer #(.WIDTH(32), .MAX_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // latency is counted in edges from the accept edge (inclusive) to first out_valid
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else if (out_valid) begin
      if (q.size() == 0) begin
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_data %h with no request pending", out_data);
        end
        seen = 1'b1;
      end else begin
        if (!seen) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        seen = 1'b1;
        if (out_ready) begin
          chk("out_data", out_data, q[0].d);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [31:0] exp, input int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_valid = 1'b1;
    q.push_back('{d: exp, lat: lat, acc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9);
    drain();
    send(32'h8000_00F0, 5'd5, 2'b10, 32'hFC00_0007, 3);
    drain();
    send(32'h8000_00F0, 5'd5, 2'b01, 32'h0400_0007, 3);
    drain();
    send(32'h1234_5678, 5'd0, 2'b01, 32'h1234_5678, 1);
    drain();
    send(32'h1234_5678, 5'd7, 2'b11, 32'h1234_5678, 1);
    drain();
    send(32'hF000_0001, 5'd4, 2'b10, 32'hFF00_0000, 2);
    drain();
    // backpressure: result must hold while downstream stalls, stray request ignored
    out_ready = 1'b0;
    send(32'h0000_000F, 5'd4, 2'b00, 32'h0000_00F0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, 32'h0000_00F0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 2);
      in_data  = 32'hDEAD_BEEF;
      in_shamt = 5'd3;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("post_stall_busy", 32'(busy), 32'd0);
    // reset in the middle of a 6-edge shift
    send(32'hFFFF_FFFF, 5'd20, 2'b01, 32'h0000_0FFF, 6);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, 2);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
